// File: rtl/shift_arbiter.sv
// Two-port arbiter sharing a single 8-bit barrel shifter.
// Round-robin or fixed-priority grant, one shift per grant, registered result.

module shifter (
    input  logic [7:0] data_i,
    input  logic [2:0] amt_i,
    input  logic       lr_i,
    input  logic       arith_i,
    output logic [7:0] result_o
);
    always_comb begin
        if (!lr_i) begin
            result_o = data_i << amt_i;
        end else if (arith_i) begin
            result_o = $unsigned($signed(data_i) >>> amt_i);
        end else begin
            result_o = data_i >> amt_i;
        end
    end
endmodule

// Handshake: a requester holds reqN high with stable operands until doneN
// pulses for one cycle; result is valid only during that pulse.
module shift_arbiter #(
    parameter int ROUND_ROBIN = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [7:0] data0,
    input  logic [2:0] amt0,
    input  logic       lr0,
    input  logic       arith0,
    input  logic       req1,
    input  logic [7:0] data1,
    input  logic [2:0] amt1,
    input  logic       lr1,
    input  logic       arith1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] result,
    output logic       busy,
    output logic       last_grant,
    output logic [1:0] state_dbg
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] data_q, data_d;
    logic [2:0] amt_q, amt_d;
    logic       lr_q, lr_d;
    logic       arith_q, arith_d;
    logic       gnt_q, gnt_d;
    logic       last_q, last_d;
    logic [7:0] result_q, result_d;
    logic       any_req;
    logic       winner;
    logic [7:0] shift_out;

    shifter u_shifter (
        .data_i   (data_q),
        .amt_i    (amt_q),
        .lr_i     (lr_q),
        .arith_i  (arith_q),
        .result_o (shift_out)
    );

    // Ties go to the port that did not win last time, or always to port 0.
    always_comb begin
        any_req = req0 | req1;
        if (req0 && req1) begin
            winner = (ROUND_ROBIN != 0) ? ~last_q : 1'b0;
        end else begin
            winner = req1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = EXEC;
            EXEC:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == EXEC) || (state_q == DONE);
        done0     = (state_q == DONE) && !gnt_q;
        done1     = (state_q == DONE) && gnt_q;
        result    = result_q;
        last_grant = last_q;
        state_dbg = state_q;
    end

    always_comb begin
        data_d   = data_q;
        amt_d    = amt_q;
        lr_d     = lr_q;
        arith_d  = arith_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_d  = winner;
                    last_d = winner;
                    if (winner) begin
                        data_d  = data1;
                        amt_d   = amt1;
                        lr_d    = lr1;
                        arith_d = arith1;
                    end else begin
                        data_d  = data0;
                        amt_d   = amt0;
                        lr_d    = lr0;
                        arith_d = arith0;
                    end
                end
            end
            EXEC:    result_d = shift_out;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q   <= 8'h00;
            amt_q    <= 3'd0;
            lr_q     <= 1'b0;
            arith_q  <= 1'b0;
            gnt_q    <= 1'b0;
            last_q   <= 1'b1;
            result_q <= 8'h00;
        end else begin
            data_q   <= data_d;
            amt_q    <= amt_d;
            lr_q     <= lr_d;
            arith_q  <= arith_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            result_q <= result_d;
        end
    end
endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: one round-robin and one fixed-priority instance
// share the same stimulus; expectations come from an arithmetic shift model.

module tb_shift_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       req0, lr0, arith0, req1, lr1, arith1;
    logic [7:0] data0, data1;
    logic [2:0] amt0, amt1;

    logic       done0_rr, done1_rr, busy_rr, lg_rr_o;
    logic [7:0] result_rr;
    logic [1:0] state_rr;
    logic       done0_fp, done1_fp, busy_fp, lg_fp_o;
    logic [7:0] result_fp;
    logic [1:0] state_fp;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];

    shift_arbiter #(.ROUND_ROBIN(1)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .data0(data0), .amt0(amt0), .lr0(lr0), .arith0(arith0),
        .req1(req1), .data1(data1), .amt1(amt1), .lr1(lr1), .arith1(arith1),
        .done0(done0_rr), .done1(done1_rr), .result(result_rr), .busy(busy_rr),
        .last_grant(lg_rr_o), .state_dbg(state_rr)
    );

    shift_arbiter #(.ROUND_ROBIN(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .data0(data0), .amt0(amt0), .lr0(lr0), .arith0(arith0),
        .req1(req1), .data1(data1), .amt1(amt1), .lr1(lr1), .arith1(arith1),
        .done0(done0_fp), .done1(done1_fp), .result(result_fp), .busy(busy_fp),
        .last_grant(lg_fp_o), .state_dbg(state_fp)
    );

    // Shift defined as multiply / floor-divide by a power of two.
    function automatic logic [7:0] ref_shift(input logic [7:0] d, input int amt,
                                             input logic lr, input logic ar);
        int p, v;
        p = 1 << amt;
        v = int'(d);
        if (!lr) begin
            v = (v * p) % 256;
        end else if (!ar) begin
            v = v / p;
        end else begin
            if (v > 127) v = v - 256;
            if (v < 0) v = -((-v + p - 1) / p);
            else v = v / p;
        end
        return 8'(v & 255);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        data0 = 8'h00; amt0 = 3'd0; lr0 = 1'b0; arith0 = 1'b0;
        data1 = 8'h00; amt1 = 3'd0; lr1 = 1'b0; arith1 = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        data0 = 8'($urandom); data1 = 8'($urandom);
        tick();
        tick();
        total++; if ({done0_rr, done1_rr, busy_rr} !== 3'b000) begin bad++; $display("FAIL reset_ctl_rr got=%b want=000", {done0_rr, done1_rr, busy_rr}); end
        total++; if (result_rr !== 8'h00) begin bad++; $display("FAIL reset_result_rr got=%h want=00", result_rr); end
        total++; if (lg_rr_o !== 1'b1) begin bad++; $display("FAIL reset_lg_rr got=%b want=1", lg_rr_o); end
        total++; if ({done0_fp, done1_fp, busy_fp, lg_fp_o} !== 4'b0001) begin bad++; $display("FAIL reset_fp got=%b want=0001", {done0_fp, done1_fp, busy_fp, lg_fp_o}); end
        req0 = 1'b0; req1 = 1'b0;
        rst_n = 1'b1;
        tick();
        tick();
        total++; if ({busy_rr, lg_rr_o} !== 2'b01) begin bad++; $display("FAIL idle_after_reset got=%b want=01", {busy_rr, lg_rr_o}); end
    endtask

    task automatic test_single_p0();
        do_reset();
        data0 = 8'h96; amt0 = 3'd3; lr0 = 1'b1; arith0 = 1'b1; req0 = 1'b1;
        tick();
        total++; if ({busy_rr, done0_rr} !== 2'b10) begin bad++; $display("FAIL single_exec got=%b want=10", {busy_rr, done0_rr}); end
        tick();
        total++; if ({done0_rr, done1_rr} !== 2'b10) begin bad++; $display("FAIL single_done got=%b want=10", {done0_rr, done1_rr}); end
        total++; if (result_rr !== 8'hF2) begin bad++; $display("FAIL single_result got=%h want=f2", result_rr); end
        req0 = 1'b0;
        tick();
        total++; if ({done0_rr, busy_rr, lg_rr_o} !== 3'b000) begin bad++; $display("FAIL single_after got=%b want=000", {done0_rr, busy_rr, lg_rr_o}); end
        total++; if (result_rr !== 8'hF2) begin bad++; $display("FAIL single_hold got=%h want=f2", result_rr); end
    endtask

    task automatic test_modes();
        logic [4:0] cases [6];
        logic [7:0] exp;
        cases[0] = {1'b1, 1'b0, 3'd3};
        cases[1] = {1'b0, 1'b0, 3'd3};
        cases[2] = {1'b1, 1'b1, 3'd0};
        cases[3] = {1'b0, 1'b0, 3'd0};
        cases[4] = {1'b1, 1'b0, 3'd0};
        cases[5] = {1'b1, 1'b1, 3'd7};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            data1 = 8'h96;
            {lr1, arith1, amt1} = cases[i];
            exp = ref_shift(data1, int'(amt1), lr1, arith1);
            req1 = 1'b1;
            tick();
            tick();
            total++; if ({done0_rr, done1_rr} !== 2'b01) begin bad++; $display("FAIL modes_done[%0d] got=%b want=01", i, {done0_rr, done1_rr}); end
            total++; if (result_rr !== exp) begin bad++; $display("FAIL modes_result[%0d] got=%h want=%h", i, result_rr, exp); end
            total++; if (result_fp !== exp) begin bad++; $display("FAIL modes_result_fp[%0d] got=%h want=%h", i, result_fp, exp); end
            req1 = 1'b0;
            tick();
        end
    endtask

    // Both held: done visible after edges 2,5,8,...; rr alternates, fp stays on port 0.
    // After the third pulse req0 drops and both instances must move to port 1.
    task automatic test_back_to_back();
        logic [7:0] e0, e1;
        logic       exp_d0_rr, exp_d1_rr, exp_d0_fp, exp_d1_fp, pulse;
        int         n;
        do_reset();
        data0 = 8'($urandom); amt0 = 3'($urandom_range(0, 7)); lr0 = 1'($urandom); arith0 = 1'($urandom);
        data1 = 8'($urandom); amt1 = 3'($urandom_range(0, 7)); lr1 = 1'($urandom); arith1 = 1'($urandom);
        e0 = ref_shift(data0, int'(amt0), lr0, arith0);
        e1 = ref_shift(data1, int'(amt1), lr1, arith1);
        req0 = 1'b1; req1 = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            pulse = (c >= 2) && ((c - 2) % 3 == 0);
            n = (c - 2) / 3;
            if (n < 3) begin
                exp_d0_rr = pulse && (n % 2 == 0);
                exp_d1_rr = pulse && (n % 2 == 1);
                exp_d0_fp = pulse;
                exp_d1_fp = 1'b0;
            end else begin
                exp_d0_rr = 1'b0;
                exp_d1_rr = pulse;
                exp_d0_fp = 1'b0;
                exp_d1_fp = pulse;
            end
            total++; if ({done0_rr, done1_rr} !== {exp_d0_rr, exp_d1_rr}) begin bad++; $display("FAIL b2b_rr_c%0d got=%b want=%b", c, {done0_rr, done1_rr}, {exp_d0_rr, exp_d1_rr}); end
            total++; if ({done0_fp, done1_fp} !== {exp_d0_fp, exp_d1_fp}) begin bad++; $display("FAIL b2b_fp_c%0d got=%b want=%b", c, {done0_fp, done1_fp}, {exp_d0_fp, exp_d1_fp}); end
            if (pulse) begin
                total++; if (result_rr !== (exp_d1_rr ? e1 : e0)) begin bad++; $display("FAIL b2b_res_rr_c%0d got=%h want=%h", c, result_rr, exp_d1_rr ? e1 : e0); end
                total++; if (result_fp !== (exp_d1_fp ? e1 : e0)) begin bad++; $display("FAIL b2b_res_fp_c%0d got=%h want=%h", c, result_fp, exp_d1_fp ? e1 : e0); end
            end
            if (c == 9) req0 = 1'b0;
        end
        req1 = 1'b0;
        tick();
        tick();
        total++; if ({busy_rr, busy_fp} !== 2'b00) begin bad++; $display("FAIL b2b_idle got=%b want=00", {busy_rr, busy_fp}); end
    endtask

    task automatic test_operand_change();
        do_reset();
        data0 = 8'h81; amt0 = 3'd1; lr0 = 1'b0; arith0 = 1'b0; req0 = 1'b1;
        tick();
        data0 = 8'h00; amt0 = 3'($urandom_range(2, 7)); lr0 = 1'b1;
        tick();
        total++; if (done0_rr !== 1'b1) begin bad++; $display("FAIL opchg_done got=%b want=1", done0_rr); end
        total++; if (result_rr !== 8'h02) begin bad++; $display("FAIL opchg_result got=%h want=02", result_rr); end
        req0 = 1'b0;
        tick();
    endtask

    task automatic test_reset_midop();
        data0 = 8'h5A; amt0 = 3'd0; lr0 = 1'b0; arith0 = 1'b0; req0 = 1'b1;
        tick();
        tick();
        req0 = 1'b0;
        tick();
        total++; if (result_rr !== 8'h5A) begin bad++; $display("FAIL midop_pre got=%h want=5a", result_rr); end
        req0 = 1'b1; data0 = 8'hC3;
        tick();
        total++; if ({busy_rr, lg_rr_o} !== 2'b10) begin bad++; $display("FAIL midop_exec got=%b want=10", {busy_rr, lg_rr_o}); end
        rst_n = 1'b0;
        tick();
        total++; if ({busy_rr, done0_rr, done1_rr} !== 3'b000) begin bad++; $display("FAIL midop_ctl got=%b want=000", {busy_rr, done0_rr, done1_rr}); end
        total++; if (result_rr !== 8'h00) begin bad++; $display("FAIL midop_result got=%h want=00", result_rr); end
        total++; if (lg_rr_o !== 1'b1) begin bad++; $display("FAIL midop_lg got=%b want=1", lg_rr_o); end
        rst_n = 1'b1; req0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if ({busy_rr, done0_rr, done1_rr} !== 3'b000) begin bad++; $display("FAIL midop_nodone%0d got=%b want=000", i, {busy_rr, done0_rr, done1_rr}); end
        end
    endtask

    task automatic test_random();
        logic [1:0] pat;
        logic       w_rr, w_fp, lg_rr, lg_fp;
        logic [7:0] e0, e1, exp;
        do_reset();
        lg_rr = 1'b1;
        lg_fp = 1'b1;
        repeat (40) begin
            pat = 2'($urandom_range(1, 3));
            data0 = 8'($urandom); amt0 = 3'($urandom_range(0, 7)); lr0 = 1'($urandom); arith0 = 1'($urandom);
            data1 = 8'($urandom); amt1 = 3'($urandom_range(0, 7)); lr1 = 1'($urandom); arith1 = 1'($urandom);
            e0 = ref_shift(data0, int'(amt0), lr0, arith0);
            e1 = ref_shift(data1, int'(amt1), lr1, arith1);
            w_rr = (pat == 2'b11) ? ~lg_rr : pat[1];
            w_fp = (pat == 2'b11) ? 1'b0 : pat[1];
            lg_rr = w_rr;
            lg_fp = w_fp;
            exp_q.push_back(w_rr ? e1 : e0);
            req0 = pat[0]; req1 = pat[1];
            tick();
            tick();
            exp = exp_q.pop_front();
            total++; if ({done0_rr, done1_rr} !== {~w_rr, w_rr}) begin bad++; $display("FAIL rand_done_rr got=%b want=%b", {done0_rr, done1_rr}, {~w_rr, w_rr}); end
            total++; if (result_rr !== exp) begin bad++; $display("FAIL rand_res_rr got=%h want=%h", result_rr, exp); end
            total++; if ({done0_fp, done1_fp} !== {~w_fp, w_fp}) begin bad++; $display("FAIL rand_done_fp got=%b want=%b", {done0_fp, done1_fp}, {~w_fp, w_fp}); end
            total++; if (result_fp !== (w_fp ? e1 : e0)) begin bad++; $display("FAIL rand_res_fp got=%h want=%h", result_fp, w_fp ? e1 : e0); end
            total++; if ({lg_rr_o, lg_fp_o} !== {lg_rr, lg_fp}) begin bad++; $display("FAIL rand_lg got=%b want=%b", {lg_rr_o, lg_fp_o}, {lg_rr, lg_fp}); end
            req0 = 1'b0; req1 = 1'b0;
            tick();
        end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_single_p0();
        test_modes();
        test_back_to_back();
        test_operand_change();
        test_reset_midop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
